// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns single core load/store requests into
// word-aligned bus transactions with alignment checks, timeout and load extension.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [2:0]  data_mem_opr,
  input  logic [3:0]  data_mem_opw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_R, DONE, ERR} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [2:0]  ld_type;
  logic [1:0]  ld_off;

  logic        access;
  logic [1:0]  size;        // 0 byte, 1 half, 2 word
  logic        misaligned;
  logic [31:0] wdata_rep;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  assign access = mem_we | mem_re;

  // A store wins when both strobes are high, so the size comes from the store mask.
  always_comb begin
    size = 2'd2;
    if (mem_we) begin
      case (data_mem_opw)
        4'b0001: size = 2'd0;
        4'b0011: size = 2'd1;
        default: size = 2'd2;
      endcase
    end else begin
      case (data_mem_opr[1:0])
        2'b00:   size = 2'd0;
        2'b01:   size = 2'd1;
        default: size = 2'd2;
      endcase
    end
  end

  assign misaligned = ((size == 2'd1) && addr[0]) ||
                      ((size == 2'd2) && (addr[1:0] != 2'b00));

  always_comb begin
    case (size)
      2'd0:    wdata_rep = {4{wdata[7:0]}};
      2'd1:    wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  assign rd_shift = bus_rdata >> {ld_off, 3'b000};

  always_comb begin
    case (ld_type[1:0])
      2'b00:   rd_ext = ld_type[2] ? {24'b0, rd_shift[7:0]}
                                   : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = ld_type[2] ? {16'b0, rd_shift[15:0]}
                                   : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  assign stall = rst_n & (((state == IDLE) & access) | (state == REQ) | (state == WAIT_R));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      ld_type   <= 3'd0;
      ld_off    <= 2'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wstrb <= 4'd0;
      bus_wdata <= 32'd0;
      rdata     <= 32'd0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state     <= REQ;
              bus_req   <= 1'b1;
              wait_cnt  <= 8'd0;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_we    <= mem_we;
              bus_wstrb <= data_mem_opw << addr[1:0];
              bus_wdata <= wdata_rep;
              ld_type   <= data_mem_opr;
              ld_off    <= addr[1:0];
            end
          end
        end
        REQ: begin
          // Timeout has priority so a grant in the expiring cycle is not honoured.
          if (wait_cnt == 8'hFF) begin
            state   <= ERR;
            err     <= 1'b1;
            bus_req <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (bus_gnt) begin
              bus_req <= 1'b0;
              if (bus_we) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= WAIT_R;
              end
            end
          end
        end
        WAIT_R: begin
          if (wait_cnt == 8'hFF) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (bus_rvalid) begin
            state <= DONE;
            done  <= 1'b1;
            rdata <= rd_ext;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized accesses
// compared against an arithmetic model of addressing, strobes and load extension.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_we, mem_re;
  logic [2:0]  data_mem_opr;
  logic [3:0]  data_mem_opw;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rdata = 32'd0;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_we(mem_we), .mem_re(mem_re),
    .data_mem_opr(data_mem_opr), .data_mem_opw(data_mem_opw),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .done(done), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int acc_size(input logic we, input logic [2:0] opr, input logic [3:0] opw);
    if (we) return (opw == 4'b0001) ? 1 : (opw == 4'b0011) ? 2 : 4;
    return (opr[1:0] == 2'b00) ? 1 : (opr[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Reference load result: pick the addressed bytes, then extend by value range.
  function automatic logic [31:0] model_load(input logic [2:0] opr, input int off, input logic [31:0] w);
    logic [31:0] s;
    logic [31:0] v;
    s = w / (32'd1 << (8 * off));
    if (opr[1:0] == 2'b00) begin
      v = s % 256;
      if (!opr[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (opr[1:0] == 2'b01) begin
      v = s % 65536;
      if (!opr[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = s;
    end
    return v;
  endfunction

  // One complete access from IDLE; caller is at posedge+1 with the DUT idle.
  task automatic run_access(input logic we, input logic re, input logic [2:0] opr,
                            input logic [3:0] opw, input logic [31:0] a, input logic [31:0] wd,
                            input int gnt_dly, input int rv_dly, input logic [31:0] brd,
                            input logic junk_rv, input string tag, output int stalls);
    int size, off;
    bit mis;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    size    = acc_size(we, opr, opw);
    off     = int'(a % 4);
    mis     = (a % size) != 0;
    e_addr  = a - (a % 4);
    e_wstrb = 4'((int'(opw) << off) % 16);
    e_wdata = (size == 1) ? (wd % 256) * 32'h0101_0101 :
              (size == 2) ? (wd % 65536) * 32'h0001_0001 : wd;
    stalls  = 0;

    mem_we = we; mem_re = re; data_mem_opr = opr; data_mem_opw = opw; addr = a; wdata = wd;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: stall=%b bus_req=%b, required stall=1 bus_req=0", tag, stall, bus_req);
    end
    if (stall === 1'b1) stalls++;
    tick();
    mem_we = 1'b0; mem_re = 1'b0;

    if (mis) begin
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || bus_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s misalign: err=%b bus_req=%b stall=%b done=%b, required 1 0 0 0",
                 tag, err, bus_req, stall, done);
      end
      tick();
      checks++;
      if (err !== 1'b0 || stall !== 1'b0 || bus_req !== 1'b0 || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL %s after_err: err=%b stall=%b bus_req=%b rdata=%h, required 0 0 0 %h",
                 tag, err, stall, bus_req, rdata, exp_rdata);
      end
      return;
    end

    for (int i = 0; i <= gnt_dly; i++) begin
      bus_gnt = (i == gnt_dly);
      bus_rvalid = junk_rv;
      bus_rdata = $urandom;
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b1 || stall !== 1'b1 || bus_addr !== e_addr || bus_we !== we) begin
        errors++;
        $display("FAIL %s req[%0d]: req=%b stall=%b addr=%h we=%b, required 1 1 %h %b",
                 tag, i, bus_req, stall, bus_addr, bus_we, e_addr, we);
      end
      if (stall === 1'b1) stalls++;
      if (we) begin
        checks++;
        if (bus_wstrb !== e_wstrb || bus_wdata !== e_wdata) begin
          errors++;
          $display("FAIL %s wr[%0d]: wstrb=%b wdata=%h, required %b %h",
                   tag, i, bus_wstrb, bus_wdata, e_wstrb, e_wdata);
        end
      end
      tick();
    end
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;

    if (!we) begin
      for (int i = 0; i <= rv_dly; i++) begin
        bus_rvalid = (i == rv_dly);
        bus_rdata = (i == rv_dly) ? brd : $urandom;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || bus_req !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s wait[%0d]: stall=%b bus_req=%b done=%b, required 1 0 0",
                   tag, i, stall, bus_req, done);
        end
        if (stall === 1'b1) stalls++;
        tick();
      end
      bus_rvalid = 1'b0;
      exp_rdata = model_load(opr, off, brd);
    end

    @(negedge clk);
    checks++;
    if (done !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0 || rdata !== exp_rdata) begin
      errors++;
      $display("FAIL %s done: done=%b stall=%b bus_req=%b rdata=%h, required 1 0 0 %h",
               tag, done, stall, bus_req, rdata, exp_rdata);
    end
    tick();
    checks++;
    if (done !== 1'b0 || rdata !== exp_rdata) begin
      errors++;
      $display("FAIL %s post: done=%b rdata=%h, required 0 %h", tag, done, rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_we = 1'b0; mem_re = 1'b1; data_mem_opr = 3'b010; data_mem_opw = 4'b0000;
    addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 ||
        bus_wstrb !== 4'h0 || bus_wdata !== 32'h0 || rdata !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: stall=%b req=%b we=%b addr=%h strb=%b wdata=%h rdata=%h done=%b err=%b, required all 0",
               stall, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, rdata, done, err);
    end
    tick();
    mem_re = 1'b0; rst_n = 1'b1;
    tick();
    $display("reset sequence checked");
  endtask

  task automatic test_store_byte();
    int st;
    run_access(1'b1, 1'b0, 3'b000, 4'b0001, 32'h1003, 32'h0000_00A5, 1, 0, 32'h0, 1'b0, "sb", st);
    checks++;
    if (st != 3) begin
      errors++;
      $display("FAIL sb_stall_cycles: got %0d, required 3", st);
    end
    $display("sb addr=0x1003 stall cycles=%0d", st);
  endtask

  task automatic test_load_ext();
    int st;
    run_access(1'b0, 1'b1, 3'b000, 4'b0000, 32'h2002, 32'h0, 0, 1, 32'h0080_FF00, 1'b0, "lb", st);
    checks++;
    if (rdata !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_value: rdata=%h, required ffffff80", rdata);
    end
    run_access(1'b0, 1'b1, 3'b100, 4'b0000, 32'h2002, 32'h0, 1, 0, 32'h0080_FF00, 1'b0, "lbu", st);
    checks++;
    if (rdata !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_value: rdata=%h, required 00000080", rdata);
    end
    $display("lb/lbu at 0x2002 rdata=%h", rdata);
  endtask

  task automatic test_misalign();
    int st;
    run_access(1'b0, 1'b1, 3'b001, 4'b0000, 32'h3001, 32'h0, 0, 0, 32'h0, 1'b0, "lh_mis", st);
    checks++;
    if (st != 1) begin
      errors++;
      $display("FAIL lh_mis_stall: got %0d stall cycles, required 1", st);
    end
    $display("lh at 0x3001 stall cycles=%0d", st);
  endtask

  task automatic test_timeout();
    int waited;
    bit seen;
    mem_re = 1'b1; data_mem_opr = 3'b010; addr = 32'h5000;
    tick();
    mem_re = 1'b0; bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    waited = 0; seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        seen = 1;
        break;
      end
      waited++;
      tick();
    end
    checks++;
    if (!seen || waited < 254 || bus_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL timeout: seen=%0d waited=%0d bus_req=%b done=%b stall=%b, required err after >=254 cycles, 0 0 0",
               seen, waited, bus_req, done, stall);
    end
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || rdata !== exp_rdata) begin
      errors++;
      $display("FAIL late_rvalid: done=%b err=%b rdata=%h, required 0 0 %h", done, err, rdata, exp_rdata);
    end
    tick();
    bus_rvalid = 1'b0;
    tick();
    checks++;
    if (rdata !== exp_rdata || done !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid_hold: rdata=%h done=%b, required %h 0", rdata, done, exp_rdata);
    end
    $display("lw timeout after %0d wait cycles, rdata=%h", waited, rdata);
  endtask

  task automatic test_reset_abort();
    int st;
    bit bad;
    run_access(1'b0, 1'b1, 3'b010, 4'b0000, 32'h6000, 32'h0, 0, 0, $urandom | 32'h1, 1'b0, "lw_pre", st);
    mem_re = 1'b1; data_mem_opr = 3'b010; addr = 32'h6004;
    tick();
    mem_re = 1'b0; bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: stall=%b, required 0", stall);
    end
    tick();
    exp_rdata = 32'h0;
    checks++;
    if (bus_req !== 1'b0 || rdata !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort: bus_req=%b rdata=%h done=%b err=%b, required 0 0 0 0", bus_req, rdata, done, err);
    end
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) bad = 1;
      tick();
    end
    bus_rvalid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_quiet: done/err pulse or rdata change after reset, required none");
    end
    run_access(1'b1, 1'b0, 3'b010, 4'b1111, 32'h4000, $urandom, 0, 0, 32'h0, 1'b0, "sw_after_rst", st);
    $display("reset in WAIT_R aborted, sw at 0x4000 completed");
  endtask

  task automatic test_both_store();
    int st;
    run_access(1'b0, 1'b1, 3'b010, 4'b0000, 32'h20, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0, "lw_seed", st);
    run_access(1'b1, 1'b1, 3'b010, 4'b1111, 32'h10, 32'h1234_5678, 0, 0, 32'h0, 1'b0, "we_re", st);
    checks++;
    if (rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL we_re_rdata: rdata=%h, required cafef00d", rdata);
    end
    $display("mem_we=mem_re=1 treated as store, rdata=%h", rdata);
  endtask

  task automatic test_random();
    int st, off;
    logic we, re;
    logic [2:0] opr;
    logic [3:0] opw;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      we  = $urandom_range(0, 1);
      re  = we ? 1'($urandom_range(0, 1)) : 1'b1;
      case ($urandom_range(0, 4))
        0: opr = 3'b000; 1: opr = 3'b001; 2: opr = 3'b010; 3: opr = 3'b100; default: opr = 3'b101;
      endcase
      case ($urandom_range(0, 2))
        0: opw = 4'b0001; 1: opw = 4'b0011; default: opw = 4'b1111;
      endcase
      off = $urandom_range(0, 3);
      a = ($urandom & 32'hFFFF_FFFC) + off;
      run_access(we, re, opr, opw, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom, 1'($urandom_range(0, 1)), "rand", st);
      $display("rand %0d: we=%b re=%b opr=%b opw=%b addr=%h rdata=%h", n, we, re, opr, opw, a, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_ext();
    test_misalign();
    test_timeout();
    test_reset_abort();
    test_both_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have these ports: clk in 1, single clock; all state updates on rising edge.
REQ-002 SHALL have rst_n in 1: synchronous, active-low reset.
REQ-003 SHALL have core-side inputs: mem_we in 1 (store); mem_re in 1 (load); data_mem_opr in 3 (load funct3: [1:0] 00 byte, 01 half, 10 word; [2] 1 = unsigned); data_mem_opw in 4 (store mask 0001/0011/1111); addr in 32; wdata in 32.
REQ-004 SHALL have core-side outputs: stall out 1 (hold PC/regfile); rdata out 32 (extended load data); done out 1 (access completion pulse); err out 1 (misalign/timeout pulse).
REQ-005 SHALL have bus outputs: bus_req out 1; bus_we out 1; bus_addr out 32 (word-aligned); bus_wstrb out 4; bus_wdata out 32.
REQ-006 SHALL have bus inputs: bus_gnt in 1 (request accepted); bus_rvalid in 1; bus_rdata in 32.

Function
REQ-007 SHALL implement FSM states IDLE, REQ, WAIT_R, DONE, ERR.
REQ-008 IDLE: access = mem_we|mem_re; aligned access -> REQ; misaligned -> ERR; none -> stay.
REQ-009 SHALL treat mem_we and mem_re both high as a store.
REQ-010 SHALL define misaligned as: half with addr[0]=1; word with addr[1:0]!=0; byte never misaligned.
REQ-011 SHALL register on leaving IDLE: bus_addr={addr[31:2],2'b00}, bus_we, bus_wstrb=mask<<addr[1:0], load type, addr[1:0].
REQ-012 SHALL register bus_wdata on leaving IDLE: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-013 bus_req SHALL be 1 exactly while in REQ; address, strobe and data SHALL hold stable until bus_gnt.
REQ-014 REQ + bus_gnt: store -> DONE; load -> WAIT_R.
REQ-015 WAIT_R + bus_rvalid -> DONE; SHALL capture bus_rdata>>(8*addr[1:0]), then sign-/zero-extend per load type into rdata.
REQ-016 SHALL ignore bus_rvalid outside WAIT_R.
REQ-017 DONE SHALL last 1 cycle, assert done=1, then -> IDLE unconditionally; no new access starts in DONE.
REQ-018 ERR SHALL last 1 cycle, assert err=1, issue no bus request, then -> IDLE.
REQ-019 stall SHALL be combinational: 1 when (IDLE and access) or state in {REQ, WAIT_R}; 0 in DONE, ERR, idle-without-access.
REQ-020 SHALL run an 8-bit wait counter, cleared on entry to REQ and counting each cycle in REQ/WAIT_R; at 255 it SHALL go to ERR, drop bus_req, and discard a late rvalid.
REQ-021 rdata SHALL hold its last captured value until the next load completes.
REQ-022 A store SHALL never modify rdata.

Reset
REQ-023 When rst_n=0 at a clock edge, SHALL go to IDLE and reset to 0: wait counter, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, rdata, done, err.
REQ-024 Reset during REQ or WAIT_R SHALL abort the access: bus_req=0 the cycle after the edge, no done/err pulse.
REQ-025 With rst_n=0, stall SHALL be 0.

Verification
REQ-026 sb: addr=0x1003, wdata=0xA5, opw=0001, gnt after 2 cycles -> bus_wstrb=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000, stall for 3 cycles, then done pulse.
REQ-027 lb then lbu: addr=0x2002, bus_rdata=0x0080FF00 -> lb rdata=0xFFFFFF80; lbu rdata=0x00000080.
REQ-028 lh at addr=0x3001 -> ERR 1 cycle, err=1, bus_req never asserted, stall high for 1 cycle only.
REQ-029 lw, gnt given, rvalid withheld 255+ cycles -> err pulse, return to IDLE; rvalid arriving later leaves rdata unchanged.
REQ-030 rst_n=0 asserted while in WAIT_R -> IDLE, bus_req=0, rdata=0, no done pulse; next sw at 0x4000 completes normally.
REQ-031 mem_we=mem_re=1, addr=0x10, wdata=0x12345678, opw=1111 -> store with bus_we=1 and bus_wstrb=1111; rdata unchanged.
